vblank_update_scheduler: RTL and testbench
==========================================

// Module: vblank_update_scheduler
// PURPOSE
// - Shares the vertical-blanking window between NUM_REQ game-logic requesters
//   (sprite/score/framebuffer updaters), so state changes never tear a visible frame.
// - Samples the vertical line count from the VGA timing generator and issues
//   round-robin, one-hot grants with a req/grant/done handshake.
// - Each requester gets at most one grant per frame, bounded by a timeout.
// PARAMETERS
// - NUM_REQ      4     number of requesters (2..8)
// - V_ACTIVE     480   first blanking line (visible lines are 0..V_ACTIVE-1)
// - V_TOTAL      525   lines per frame; the line count wraps V_TOTAL-1 -> 0
// - GUARD_LINES  2     no grant is started or held at or after line V_TOTAL-GUARD_LINES
// - SLOT_MAX     1600  max clk cycles one grant may be held
// PORTS
// - clk          in   1        system clock (2x pixel clock)
// - rst_n        in   1        asynchronous active-low reset
// - y_count      in   16       vertical line count from the timing generator
// - req          in   NUM_REQ  level request, one bit per requester
// - done         in   NUM_REQ  1-cycle pulse: requester has finished its update
// - grant        out  NUM_REQ  one-hot (or zero) grant, registered
// - vblank       out  1        y_q >= V_ACTIVE
// - frame_start  out  1        1-cycle pulse when y_q becomes 0
// - busy         out  1        state == GRANT
// - timeout_err  out  1        1-cycle pulse: grant revoked by SLOT_MAX
// - overrun_err  out  1        1-cycle pulse: grant revoked by window close
// BEHAVIOUR
// - Reset: grant=0, all pulses=0, busy=0, y_q=0, served=0, rr_ptr=0, state=VIDEO.
//   Applies immediately in any state, including mid-grant.
// - Sampling: y_q <= y_count every clk. All decisions use y_q.
// - Window: win = (y_q >= V_ACTIVE) && (y_q < V_TOTAL-GUARD_LINES).
// - frame_start: pulses when y_q==0 and the previous y_q!=0. Clears served[].
// - FSM:
//   - VIDEO: on win -> ARB.
//   - ARB: elig = req & ~served.
//     - If !win -> VIDEO.
//     - Else if elig!=0: pick the first set bit searching from rr_ptr upward
//       with wrap; set grant one-hot next cycle; slot counter = 0; -> GRANT.
//     - Else stay in ARB.
//   - GRANT: priority order:
//     1. done[g] -> grant=0 next cycle, served[g]=1, rr_ptr=(g+1)%NUM_REQ, -> ARB.
//     2. !win -> grant=0, overrun_err pulse, served[g]=1, -> VIDEO.
//     3. slot==SLOT_MAX-1 -> grant=0, timeout_err pulse, served[g]=1,
//        rr_ptr=g+1, -> ARB.
//     - done and window close on the same cycle: done wins, no error.
//     - The slot counter saturates.
// - Latency: ARB->grant is 1 cycle. done->grant low is 1 cycle.
//   At least one idle ARB cycle separates consecutive grants.
// - done bits for non-granted indices are ignored.
// - Dropping req while granted does not revoke the grant.
// - rr_ptr persists across frames; served[] does not.
// - grant never asserts while y_q < V_ACTIVE or y_q >= V_TOTAL-GUARD_LINES
//   (1-cycle y_q lag excepted for revocation).
// CONFIGURATION
// - VBLANK_SCHED_STATS_EN defined: adds output missed_cnt[7:0].
//   - At window close it adds popcount(req & ~served), saturating at 255.
//   - Reset 0; never wraps.
// - VBLANK_SCHED_STATS_EN undefined: the port and its logic are absent;
//   all other behaviour is identical.
// TESTING
// - Reset mid-GRANT (y=490, grant=0010): rst_n low -> grant=0000, busy=0
//   asynchronously; after release, state=VIDEO.
// - req=1111 at y=480, each done 3 cycles after its grant -> grants 0001,0010,
//   0100,1000 in order; each requester once only; no second round in this frame.
// - Next frame, rr_ptr=1 after last served idx0, req=0011 -> grant 0010 first, then 0001.
// - grant held, done never: timeout_err pulse exactly SLOT_MAX cycles after grant
//   rose; grant=0 the same cycle; next eligible requester granted.
// - grant active when y_q reaches 523 -> grant=0, overrun_err=1 for 1 cycle;
//   no new grant until y_q>=480 in the next frame.
// - STATS_EN, req=0111 at 480, no done, SLOT_MAX large -> at 523 missed_cnt += 2;
//   with req held over 300 frames, missed_cnt saturates at 255.

Source files
------------

// File: rtl/vblank_update_scheduler.sv
// Round-robin scheduler that hands the vertical-blanking window to one requester at a time.
// Optional VBLANK_SCHED_STATS_EN adds missed_cnt, a saturating count of requests left unserved at window close.
module vblank_update_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int GUARD_LINES = 2,
  parameter int SLOT_MAX    = 1600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        y_count,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               vblank,
  output logic               frame_start,
  output logic               busy,
  output logic               timeout_err,
  output logic               overrun_err
`ifdef VBLANK_SCHED_STATS_EN
  ,
  output logic [7:0]         missed_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(SLOT_MAX + 1);
  localparam logic [15:0]   WIN_LO    = 16'(V_ACTIVE);
  localparam logic [15:0]   WIN_HI    = 16'(V_TOTAL - GUARD_LINES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_MAX - 1);
  localparam logic [NUM_REQ-1:0] ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {VIDEO, ARB, GRANT} state_t;

  state_t             state_q;
  logic [15:0]        y_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] served_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [SW-1:0]      slot_q;
  logic               fs_q;
  logic               to_q;
  logic               ov_q;
  logic               win_prev_q;

  logic               win;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rot_elig;
  logic [IW-1:0]      pick_off;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      next_ptr;
  logic               done_hit;
  logic               slot_end;
  logic [NUM_REQ-1:0] served_set;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  assign win  = (y_q >= WIN_LO) && (y_q < WIN_HI);
  assign elig = req & ~served_q;

  // Rotate eligibility so that bit 0 is the requester at rr_ptr.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_elig[gi] = elig[wrap_add(rr_ptr_q, gi)];
    end
  endgenerate

  always_comb begin
    pick_off   = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_elig[i]) begin
        pick_off   = IW'(i);
        pick_valid = 1'b1;
      end
    end
  end

  assign pick_idx = wrap_add(rr_ptr_q, int'(pick_off));

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) gnt_idx = IW'(i);
    end
  end

  assign next_ptr   = wrap_add(gnt_idx, 1);
  assign done_hit   = |(done & grant_q);
  assign slot_end   = (slot_q == SLOT_LAST);
  assign served_set = ((state_q == GRANT) && (done_hit || !win || slot_end)) ? grant_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VIDEO;
      y_q        <= '0;
      grant_q    <= '0;
      served_q   <= '0;
      rr_ptr_q   <= '0;
      slot_q     <= '0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
      ov_q       <= 1'b0;
      win_prev_q <= 1'b0;
    end else begin
      y_q        <= y_count;
      win_prev_q <= win;
      fs_q       <= (y_count == 16'd0) && (y_q != 16'd0);
      to_q       <= 1'b0;
      ov_q       <= 1'b0;
      served_q   <= fs_q ? '0 : (served_q | served_set);
      case (state_q)
        VIDEO: begin
          if (win) state_q <= ARB;
        end
        ARB: begin
          if (!win) begin
            state_q <= VIDEO;
          end else if (pick_valid) begin
            grant_q <= ONE << pick_idx;
            slot_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // A done on the closing cycle still counts as a clean finish.
          if (done_hit) begin
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= ARB;
          end else if (!win) begin
            grant_q <= '0;
            ov_q    <= 1'b1;
            state_q <= VIDEO;
          end else if (slot_end) begin
            grant_q  <= '0;
            to_q     <= 1'b1;
            rr_ptr_q <= next_ptr;
            state_q  <= ARB;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= VIDEO;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign vblank      = (y_q >= WIN_LO);
  assign frame_start = fs_q;
  assign busy        = (state_q == GRANT);
  assign timeout_err = to_q;
  assign overrun_err = ov_q;

`ifdef VBLANK_SCHED_STATS_EN
  logic [7:0] missed_q;
  logic [3:0] miss_pop;
  logic [8:0] miss_sum;
  logic [NUM_REQ-1:0] unserved;

  // Include any grant revoked on the closing cycle as served.
  assign unserved = req & ~(served_q | served_set);

  always_comb begin
    miss_pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      miss_pop = miss_pop + {3'b000, unserved[i]};
    end
  end

  assign miss_sum = {1'b0, missed_q} + {5'b00000, miss_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missed_q <= '0;
    end else if (win_prev_q && !win) begin
      missed_q <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
  end

  assign missed_cnt = missed_q;
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/errors, a monitor pops them as the DUT reports.
module tb_vblank_update_scheduler;

  localparam int NREQ = 4;
  localparam int SLOT = 40;
  localparam int K_GRANT = 0;
  localparam int K_TO    = 1;
  localparam int K_OV    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     y_count = 16'd0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] auto_done = '0;
  logic [NREQ-1:0] man_done = '0;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic            vblank, frame_start, busy, timeout_err, overrun_err;
`ifdef VBLANK_SCHED_STATS_EN
  logic [7:0]      missed_cnt;
`endif

  assign done = auto_done | man_done;

  vblank_update_scheduler #(
    .NUM_REQ(NREQ), .V_ACTIVE(480), .V_TOTAL(525), .GUARD_LINES(2), .SLOT_MAX(SLOT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .y_count(y_count), .req(req), .done(done),
    .grant(grant), .vblank(vblank), .frame_start(frame_start), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
`ifdef VBLANK_SCHED_STATS_EN
    , .missed_cnt(missed_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              kind;
    logic [NREQ-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   auto_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push(input int kind, input logic [NREQ-1:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_y(input int v);
    @(negedge clk);
    y_count = 16'(v);
  endtask

  task automatic new_frame();
    set_y(523); cycles(3);
    set_y(0);   cycles(3);
    set_y(100); cycles(2);
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] want);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check(name, grant, want);
  endtask

  // Requester model: pulses done three cycles after its grant rises.
  initial begin
    logic [NREQ-1:0] gp;
    int cnt;
    gp = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      auto_done = '0;
      if (grant != '0 && gp == '0) cnt = 0;
      else if (grant != '0) cnt++;
      if (auto_en && grant != '0 && cnt == 2) auto_done = grant;
      gp = grant;
    end
  end

  // Monitor: compares each grant rise and error pulse against the scoreboard.
  initial begin
    logic [NREQ-1:0] gp;
    int cyc;
    exp_t e;
    gp = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (grant != '0 && gp == '0) begin
        cyc = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_grant", 32'(e.kind), 32'(K_GRANT));
          check("grant_value", 32'(grant), 32'(e.val));
        end
      end else begin
        cyc++;
      end
      if (grant != '0 && gp != '0 && grant != gp) check("grant_stable", 32'(grant), 32'(gp));
      if (grant != '0) check("grant_onehot", 32'($onehot(grant)), 1);
      if (timeout_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_timeout", 32'(timeout_err), 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_timeout", 32'(e.kind), 32'(K_TO));
          check("timeout_latency", 32'(cyc), 32'(SLOT));
          check("timeout_grant_low", 32'(grant), 0);
        end
      end
      if (overrun_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_overrun", 32'(overrun_err), 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_overrun", 32'(e.kind), 32'(K_OV));
          check("overrun_grant_low", 32'(grant), 0);
        end
      end
      gp = grant;
    end
  end

  initial begin
    // Reset values
    cycles(2);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_vblank", 32'(vblank), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_overrun", 32'(overrun_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // frame_start pulses once when y_q returns to 0
    set_y(100); cycles(2);
    set_y(0);
    @(negedge clk);
    check("frame_start_pulse", 32'(frame_start), 1);
    @(negedge clk);
    check("frame_start_single", 32'(frame_start), 0);
    check("vblank_low_visible", 32'(vblank), 0);

    // Full round robin, one grant each, no second round
    auto_en = 1'b1;
    push(K_GRANT, 4'b0001); push(K_GRANT, 4'b0010);
    push(K_GRANT, 4'b0100); push(K_GRANT, 4'b1000);
    req = 4'b1111;
    set_y(480);
    @(negedge clk);
    check("vblank_high", 32'(vblank), 1);
    cycles(40);
    check("rr_idle_busy", 32'(busy), 0);
    req = '0;
    new_frame();

    // Serve only idx0 so rr_ptr lands on 1
    push(K_GRANT, 4'b0001);
    req = 4'b0001;
    set_y(480); cycles(20);
    req = '0;
    new_frame();

    // rr_ptr=1 with req=0011: idx1 first
    push(K_GRANT, 4'b0010); push(K_GRANT, 4'b0001);
    req = 4'b0011;
    set_y(480); cycles(30);
    req = '0;
    new_frame();

    // Timeouts, then hand-over to next eligible requester
    auto_en = 1'b0;
    push(K_GRANT, 4'b0010); push(K_TO, 4'b0000);
    push(K_GRANT, 4'b0001); push(K_TO, 4'b0000);
    req = 4'b0011;
    set_y(480); cycles(100);
    req = '0;
    new_frame();

    // Overrun at line 523, nothing until the next window
    push(K_GRANT, 4'b0100); push(K_OV, 4'b0000);
    req = 4'b0100;
    set_y(480); cycles(10);
    set_y(523); cycles(4);
    check("overrun_busy_low", 32'(busy), 0);
    set_y(524); cycles(2);
    set_y(0);   cycles(2);
    set_y(100); cycles(3);
    auto_en = 1'b1;
    push(K_GRANT, 4'b0100);
    set_y(480); cycles(15);
    req = '0;

    // done on the closing cycle wins over overrun
    auto_en = 1'b0;
    push(K_GRANT, 4'b1000);
    req = 4'b1000;
    wait_grant("wait_grant_close", 4'b1000);
    set_y(523);
    @(negedge clk);
    man_done = 4'b1000;
    @(negedge clk);
    man_done = '0;
    check("close_done_grant_low", 32'(grant), 0);
    check("close_done_busy_low", 32'(busy), 0);
    req = '0;
    cycles(3);
    set_y(0);   cycles(2);
    set_y(100); cycles(2);

`ifdef VBLANK_SCHED_STATS_EN
    check("stats_start", 32'(missed_cnt), 0);
    push(K_GRANT, 4'b0001); push(K_OV, 4'b0000);
    req = 4'b0111;
    set_y(480); cycles(20);
    set_y(523); cycles(3);
    check("stats_missed_2", 32'(missed_cnt), 2);
    for (int f = 0; f < 100; f++) begin
      set_y(0); cycles(1);
      set_y(480);
      set_y(523); cycles(1);
      if (f == 0) check("stats_missed_5", 32'(missed_cnt), 5);
    end
    check("stats_saturate", 32'(missed_cnt), 255);
    req = '0;
    set_y(0);   cycles(2);
    set_y(100); cycles(2);
`endif

    // Asynchronous reset mid-grant, then restart from VIDEO
    push(K_GRANT, 4'b0010);
    req = 4'b0010;
    set_y(490);
    wait_grant("wait_grant_rst", 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 0);
    check("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(grant), 0);
    check("post_rst_busy", 32'(busy), 0);
    push(K_GRANT, 4'b0010);
    cycles(10);
    push(K_OV, 4'b0000);
    set_y(523); cycles(4);
    req = '0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
